// File: rtl/des_sbox_pkg.sv
// Shared types and constants for the time-multiplexed DES S-box scheduler.
// The S-box table is stored per row as 16 packed nibbles, indexed [box][row][column].
package des_sbox_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam int unsigned NUM_SBOX   = 8;
  localparam int unsigned SBOX_IN_W  = 6;
  localparam int unsigned SBOX_OUT_W = 4;

  // Ascending packed range puts column 0 in the leftmost hex digit of each literal.
  localparam logic [0:15][3:0] SBOX_TABLE [NUM_SBOX][4] = '{
    '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
    '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
    '{64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
    '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
    '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
    '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
    '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
    '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
  };

endpackage

// File: rtl/des_sbox_lookup.sv
// Combinational single S-box lookup: selects box, row {b5,b0} and column b[4:1].
module des_sbox_lookup
  import des_sbox_pkg::*;
(
  input  logic [2:0]            box_i,
  input  logic [SBOX_IN_W-1:0]  chunk_i,
  output logic [SBOX_OUT_W-1:0] value_o
);

  logic [1:0] row;
  logic [3:0] col;

  always_comb begin
    row     = {chunk_i[5], chunk_i[0]};
    col     = chunk_i[4:1];
    value_o = SBOX_TABLE[box_i][row][col];
  end

endmodule

// File: rtl/des_sbox_scheduler.sv
// Evaluates S1..S8 over a 48-bit word through shared lookup lane(s), one box per lane per cycle.
// Define DES_SBOX_DUAL_LANE_EN for two lookup lanes (4 RUN cycles instead of 8).
module des_sbox_scheduler
  import des_sbox_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

`ifdef DES_SBOX_DUAL_LANE_EN
  localparam int unsigned NUM_LANES = 2;
`else
  localparam int unsigned NUM_LANES = 1;
`endif
  localparam logic [2:0] LAST = 3'(NUM_SBOX / NUM_LANES - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [47:0] in_q, in_d;
  logic [31:0] res_q, res_d;

  logic [2:0]            lane_box   [NUM_LANES];
  logic [SBOX_IN_W-1:0]  lane_chunk [NUM_LANES];
  logic [SBOX_OUT_W-1:0] lane_val   [NUM_LANES];

  // Lane l handles box cnt*NUM_LANES + l; chunks are picked with constant slices.
  always_comb begin
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      lane_box[l]   = 3'((32'(cnt_q) * NUM_LANES) + l);
      lane_chunk[l] = '0;
      for (int unsigned b = 0; b < NUM_SBOX; b++) begin
        if (lane_box[l] == 3'(b)) begin
          lane_chunk[l] = in_q[SBOX_IN_W*(NUM_SBOX-1-b) +: SBOX_IN_W];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    des_sbox_lookup u_lookup (
      .box_i   (lane_box[g]),
      .chunk_i (lane_chunk[g]),
      .value_o (lane_val[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid)        state_d = StRun;
      StRun:   if (cnt_q == LAST)   state_d = StDone;
      StDone:  if (out_ready)       state_d = StIdle;
      default:                      state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
  end

  assign out_data = res_q;

  always_comb begin
    cnt_d = cnt_q;
    in_d  = in_q;
    res_d = res_q;
    if (state_q == StIdle && in_valid) begin
      in_d  = in_data;
      cnt_d = '0;
      res_d = '0;
    end else if (state_q == StRun) begin
      if (cnt_q != LAST) begin
        cnt_d = cnt_q + 3'd1;
      end
      for (int unsigned l = 0; l < NUM_LANES; l++) begin
        for (int unsigned b = 0; b < NUM_SBOX; b++) begin
          if (lane_box[l] == 3'(b)) begin
            res_d[SBOX_OUT_W*(NUM_SBOX-1-b) +: SBOX_OUT_W] = lane_val[l];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      in_q  <= '0;
      res_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      in_q  <= in_d;
      res_q <= res_d;
    end
  end

endmodule

// File: tb/tb_des_sbox_scheduler.sv
// Directed bench for des_sbox_scheduler: vector table, S3 sweep, backpressure, reset, streaming.
module tb_des_sbox_scheduler;

`ifdef DES_SBOX_DUAL_LANE_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 8;
`endif
  localparam int SPACING = LAT + 2;
  localparam int MID     = (LAT + 1) / 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  des_sbox_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] din;
    logic [31:0] dout;
  } vec_t;

  vec_t        vecs [5];
  logic [63:0] s3_rows [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic accept(input logic [47:0] d);
    check("accept_ready", 64'(in_ready), 64'd1);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = ~d;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic do_word(input logic [47:0] d, output logic [31:0] r, output int lat);
    accept(d);
    wait_out(lat);
    r = out_data;
    drain();
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] s3_first [2];
    int          lat;
    int          acc_cyc [3];
    int          out_cyc [3];
    logic [31:0] got [3];
    int          nacc;
    int          ndone;
    logic        acc;

    vecs[0] = '{48'h0000_0000_0000, 32'hEFA72C4D};
    vecs[1] = '{48'hFFFF_FFFF_FFFF, 32'hD9CE3DCB};
    vecs[2] = '{48'h0410_4104_1041, 32'h03DDEAD1};
    vecs[3] = '{48'h8208_2082_0820, 32'h40DA4917};
    vecs[4] = '{48'h79E7_9E79_E79E, 32'h7A8F9B17};
    s3_rows[0] = 64'hA09E63F51DC7B428;
    s3_rows[1] = 64'hD709346A285ECBF1;
    s3_rows[2] = 64'hD6498F30B12C5AE7;
    s3_rows[3] = 64'h1AD069874FE3B52C;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      do_word(vecs[i].din, r, lat);
      check($sformatf("vec%0d_data", i), 64'(r), 64'(vecs[i].dout));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(LAT));
    end

    // Sweep S3 chunk; other boxes see chunk 0 and keep their zero-input values.
    for (int v = 0; v < 64; v++) begin
      logic [5:0]  c;
      logic [63:0] rw;
      logic [3:0]  nib;
      int          col;
      c   = 6'(v);
      rw  = s3_rows[{c[5], c[0]}];
      col = int'(c[4:1]);
      nib = rw[60 - 4*col +: 4];
      do_word({12'h000, c, 30'h0}, r, lat);
      check($sformatf("s3_chunk%0d", v), 64'(r),
            64'((32'hEFA72C4D & 32'hFF0FFFFF) | {8'h00, nib, 20'h00000}));
      if (v < 2) s3_first[v] = r;
    end
    check("s3_chunk0_const", 64'(s3_first[0]), 64'h0000_0000_EFA7_2C4D);
    check("s3_chunk1_const", 64'(s3_first[1]), 64'h0000_0000_EFD7_2C4D);

    // Backpressure: hold DONE for five cycles with a competing in_valid.
    accept(vecs[0].din);
    wait_out(lat);
    check("bp_latency", 64'(lat), 64'(LAT));
    in_valid = 1'b1;
    in_data  = vecs[1].din;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_hold%0d", k), 64'({out_valid, in_ready, out_data}),
            64'({1'b1, 1'b0, vecs[0].dout}));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_drain_idle", 64'({out_valid, in_ready}), 64'b01);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_new_accept_busy", 64'(busy), 64'd1);
    wait_out(lat);
    check("bp_new_latency", 64'(lat), 64'(LAT));
    check("bp_new_data", 64'(out_data), 64'(vecs[1].dout));
    drain();

    // Reset partway through RUN discards the transaction.
    accept(vecs[1].din);
    repeat (MID) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_outputs", 64'({in_ready, out_valid, busy, out_data}),
          64'({1'b1, 1'b0, 1'b0, 32'h0}));
    do_word(vecs[2].din, r, lat);
    check("midrst_next_data", 64'(r), 64'(vecs[2].dout));

    // Streaming with in_valid and out_ready held high.
    nacc      = 0;
    ndone     = 0;
    in_valid  = 1'b1;
    in_data   = vecs[1].din;
    out_ready = 1'b1;
    for (int c = 0; c < 80 && ndone < 3; c++) begin
      @(negedge clk);
      acc = in_ready && in_valid;
      if (acc) acc_cyc[nacc] = c;
      if (out_valid && ndone < 3) begin
        got[ndone]     = out_data;
        out_cyc[ndone] = c;
        ndone++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        nacc++;
        if (nacc < 3) in_data = vecs[nacc+1].din;
        else          in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_outputs", 64'(ndone), 64'd3);
    check("b2b_accepts", 64'(nacc), 64'd3);
    if (ndone == 3 && nacc == 3) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("b2b_data%0d", i), 64'(got[i]), 64'(vecs[i+1].dout));
        check($sformatf("b2b_lat%0d", i), 64'(out_cyc[i] - acc_cyc[i]), 64'(LAT + 1));
      end
      check("b2b_spacing01", 64'(acc_cyc[1] - acc_cyc[0]), 64'(SPACING));
      check("b2b_spacing12", 64'(acc_cyc[2] - acc_cyc[1]), 64'(SPACING));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
